// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : Drains a 4-bit push-button FIFO one entry at a time. Each
//                entry is popped with a held deq pulse, sampled after the
//                FIFO read latency, converted to an ASCII hex digit and sent
//                as one 8N1 UART frame on txd.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
  parameter int CLK_DIV  = 868,
  parameter int DEQ_HOLD = 2,
  parameter int RD_LAT   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       empty_i,
  input  logic [3:0] fifo_out_i,
  output logic       deq_o,
  output logic       txd_o,
  output logic       busy_o,
  output logic [7:0] sent_cnt_o
);

  // One shared counter times the deq hold, the read wait and each UART bit,
  // so it is sized for the largest of the three intervals.
  localparam int c_max01   = (CLK_DIV > DEQ_HOLD) ? CLK_DIV : DEQ_HOLD;
  localparam int c_cnt_max = (c_max01 > RD_LAT) ? c_max01 : RD_LAT;
  localparam int c_cnt_w   = (c_cnt_max > 2) ? $clog2(c_cnt_max) : 1;

  localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(CLK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_deq_last  = c_cnt_w'(DEQ_HOLD - 1);
  localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEQ   = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t             state_q;
  logic [c_cnt_w-1:0] cnt_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q;
  logic               deq_q;
  logic               txd_q;
  logic               busy_q;
  logic [7:0]         sent_q;

  // Nibble to ASCII hex digit: '0'..'9' then 'A'..'F'.
  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

  // Pop / wait / frame sequencer; every output is a flop in this block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= 8'hFF;
      deq_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      sent_q  <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          cnt_q <= '0;
          if (en_i && !empty_i) begin
            deq_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= DEQ;
          end
        end
        DEQ: begin
          if (cnt_q == c_deq_last) begin
            deq_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= WAIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == c_wait_last) begin
            shift_q <= to_ascii(fifo_out_i);
            txd_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= START;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        START: begin
          if (cnt_q == c_baud_last) begin
            txd_q   <= shift_q[0];
            shift_q <= {1'b1, shift_q[7:1]};
            bit_q   <= '0;
            cnt_q   <= '0;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == c_baud_last) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              txd_q   <= shift_q[0];
              shift_q <= {1'b1, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == c_baud_last) begin
            sent_q  <= sent_q + 8'd1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign deq_o      = deq_q;
  assign txd_o      = txd_q;
  assign busy_o     = busy_q;
  assign sent_cnt_o = sent_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Bench for fifo_uart_tx with a queue-based FIFO model and a
//                UART frame decoder that samples txd at mid-bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

  localparam int CD = 4;
  localparam int DH = 2;
  localparam int RL = 4;

  logic       clk        = 1'b0;
  logic       rst        = 1'b0;
  logic       en_i       = 1'b0;
  logic       empty_i    = 1'b1;
  logic [3:0] fifo_out_i = 4'h0;
  logic       deq_o;
  logic       txd_o;
  logic       busy_o;
  logic [7:0] sent_cnt_o;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int exp_sent = 0;

  // FIFO model: entries are appended by the tests, popped on deq rising edge.
  logic [3:0] q[$];
  int         pop_idx = 0;
  logic       m_prev  = 1'b0;

  // deq pulse monitor results
  int   pulse_cnt     = 0;
  int   width         = 0;
  int   last_width    = 0;
  int   last_fall_cyc = 0;
  int   last_gap      = 0;
  logic d_prev        = 1'b0;

  string hexs = "0123456789ABCDEF";

  fifo_uart_tx #(
    .CLK_DIV (CD),
    .DEQ_HOLD(DH),
    .RD_LAT  (RL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en_i),
    .empty_i   (empty_i),
    .fifo_out_i(fifo_out_i),
    .deq_o     (deq_o),
    .txd_o     (txd_o),
    .busy_o    (busy_o),
    .sent_cnt_o(sent_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous FIFO: a rising deq moves the head to the output register.
  always @(posedge clk) begin
    if (deq_o === 1'b1 && m_prev !== 1'b1) begin
      if (pop_idx < q.size()) begin
        fifo_out_i <= q[pop_idx];
        pop_idx = pop_idx + 1;
      end
    end
    m_prev = deq_o;
    empty_i <= (pop_idx >= q.size());
  end

  // Measures deq pulse widths and the low gap between pulses.
  always @(negedge clk) begin
    if (deq_o === 1'b1) begin
      if (d_prev !== 1'b1) begin
        pulse_cnt = pulse_cnt + 1;
        last_gap  = cyc - last_fall_cyc;
        width     = 0;
      end
      width = width + 1;
    end else if (d_prev === 1'b1) begin
      last_width    = width;
      last_fall_cyc = cyc;
    end
    d_prev = deq_o;
  end

  function automatic logic [7:0] ref_ascii(input logic [3:0] n);
    return hexs[n];
  endfunction

  // Observes one frame; returns decoded fields, no judging here.
  task automatic capture_frame(input int drop_bit, output logic [7:0] data,
                               output logic s_bit, output logic p_bit,
                               output int len, output int lat, output bit tmo);
    int n;
    int t0;
    tmo = 1'b0; data = 8'h00; s_bit = 1'b1; p_bit = 1'b0; len = 0; lat = 0;
    n = 0;
    while (txd_o !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (txd_o !== 1'b0) begin
      tmo = 1'b1;
      return;
    end
    t0  = cyc;
    lat = t0 - last_fall_cyc;
    repeat (CD / 2) @(negedge clk);
    s_bit = txd_o;
    for (int k = 1; k <= 8; k++) begin
      repeat (CD) @(negedge clk);
      if (k == drop_bit) en_i = 1'b0;
      data[k-1] = txd_o;
    end
    repeat (CD) @(negedge clk);
    p_bit = txd_o;
    n = 0;
    while (busy_o !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy_o !== 1'b0) tmo = 1'b1;
    len = cyc - t0;
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    en_i = 1'b1;
    q.push_back(4'hA);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (txd_o !== 1'b1 || deq_o !== 1'b0 || busy_o !== 1'b0 || sent_cnt_o !== 8'd0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: txd=%b deq=%b busy=%b sent=%0d, want 1 0 0 0",
                 i, txd_o, deq_o, busy_o, sent_cnt_o);
      end
    end
    en_i = 1'b0;
    rst  = 1'b1;
    exp_sent = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (txd_o !== 1'b1 || deq_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_en0: txd=%b deq=%b busy=%b, want 1 0 0", txd_o, deq_o, busy_o);
    end
  endtask

  task automatic test_single();
    logic [7:0] d; logic sb, pb; int len, lat; bit tmo; int p0;
    p0   = pulse_cnt;
    en_i = 1'b1;
    capture_frame(-1, d, sb, pb, len, lat, tmo);
    checks++;
    if (tmo || d !== ref_ascii(4'hA) || sb !== 1'b0 || pb !== 1'b1) begin
      errors++;
      $display("FAIL single_frame: data=%h start=%b stop=%b tmo=%0d, want data=%h start=0 stop=1",
               d, sb, pb, tmo, ref_ascii(4'hA));
    end
    checks++;
    if (last_width !== DH || lat !== RL || len !== 10 * CD) begin
      errors++;
      $display("FAIL single_timing: deq_w=%0d lat=%0d len=%0d, want %0d %0d %0d",
               last_width, lat, len, DH, RL, 10 * CD);
    end
    exp_sent++;
    repeat (10) @(negedge clk);
    checks++;
    if (sent_cnt_o !== 8'(exp_sent) || busy_o !== 1'b0 || txd_o !== 1'b1 || pulse_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL single_after: sent=%0d busy=%b txd=%b pulses=%0d, want %0d 0 1 1",
               sent_cnt_o, busy_o, txd_o, pulse_cnt - p0, exp_sent);
    end
  endtask

  task automatic run_list(input string name, input logic [3:0] vals[$]);
    logic [7:0] d; logic sb, pb; int len, lat; bit tmo;
    foreach (vals[i]) q.push_back(vals[i]);
    en_i = 1'b1;
    foreach (vals[i]) begin
      capture_frame(-1, d, sb, pb, len, lat, tmo);
      checks++;
      if (tmo || d !== ref_ascii(vals[i]) || sb !== 1'b0 || pb !== 1'b1 || len !== 10 * CD || lat !== RL) begin
        errors++;
        $display("FAIL %s[%0d]: data=%h start=%b stop=%b len=%0d lat=%0d tmo=%0d, want data=%h 0 1 %0d %0d",
                 name, i, d, sb, pb, len, lat, tmo, ref_ascii(vals[i]), 10 * CD, RL);
      end
      exp_sent++;
    end
    checks++;
    if (sent_cnt_o !== 8'(exp_sent)) begin
      errors++;
      $display("FAIL %s_count: sent=%0d, want %0d", name, sent_cnt_o, exp_sent);
    end
  endtask

  task automatic test_mapping();
    logic [3:0] v[$];
    v = '{4'h0, 4'h7, 4'h9, 4'hF};
    run_list("mapping", v);
  endtask

  task automatic test_random();
    logic [3:0] v[$];
    for (int i = 0; i < 6; i++) v.push_back(4'($urandom_range(15)));
    run_list("random", v);
  endtask

  task automatic test_back_to_back();
    logic [3:0] v[3];
    logic [7:0] d; logic sb, pb; int len, lat; bit tmo; int p0;
    v = '{4'h3, 4'h9, 4'hC};
    p0 = pulse_cnt;
    foreach (v[i]) q.push_back(v[i]);
    en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      capture_frame(-1, d, sb, pb, len, lat, tmo);
      checks++;
      if (tmo || d !== ref_ascii(v[i]) || sb !== 1'b0 || pb !== 1'b1) begin
        errors++;
        $display("FAIL b2b_data[%0d]: data=%h tmo=%0d, want %h", i, d, tmo, ref_ascii(v[i]));
      end
      if (i > 0) begin
        checks++;
        if (last_width !== DH || last_gap < RL + 10 * CD) begin
          errors++;
          $display("FAIL b2b_deq[%0d]: width=%0d gap=%0d, want width=%0d gap>=%0d",
                   i, last_width, last_gap, DH, RL + 10 * CD);
        end
      end
      exp_sent++;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (sent_cnt_o !== 8'(exp_sent) || pulse_cnt - p0 !== 3 || txd_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: sent=%0d pulses=%0d txd=%b busy=%b, want %0d 3 1 0",
               sent_cnt_o, pulse_cnt - p0, txd_o, busy_o, exp_sent);
    end
  endtask

  task automatic test_en_drop();
    logic [3:0] a, b;
    logic [7:0] d; logic sb, pb; int len, lat; bit tmo; int p0;
    a = 4'($urandom_range(15));
    b = 4'($urandom_range(15));
    q.push_back(a);
    q.push_back(b);
    en_i = 1'b1;
    capture_frame(3, d, sb, pb, len, lat, tmo);
    exp_sent++;
    checks++;
    if (tmo || d !== ref_ascii(a) || sb !== 1'b0 || pb !== 1'b1 || len !== 10 * CD) begin
      errors++;
      $display("FAIL endrop_frame: data=%h len=%0d tmo=%0d, want %h %0d", d, len, tmo, ref_ascii(a), 10 * CD);
    end
    p0 = pulse_cnt;
    repeat (20) @(negedge clk);
    checks++;
    if (pulse_cnt !== p0 || busy_o !== 1'b0 || sent_cnt_o !== 8'(exp_sent)) begin
      errors++;
      $display("FAIL endrop_hold: new_pulses=%0d busy=%b sent=%0d, want 0 0 %0d",
               pulse_cnt - p0, busy_o, sent_cnt_o, exp_sent);
    end
    en_i = 1'b1;
    @(negedge clk);
    checks++;
    if (deq_o !== 1'b1) begin
      errors++;
      $display("FAIL endrop_restart: deq=%b, want 1", deq_o);
    end
    capture_frame(-1, d, sb, pb, len, lat, tmo);
    exp_sent++;
    checks++;
    if (tmo || d !== ref_ascii(b) || sent_cnt_o !== 8'(exp_sent)) begin
      errors++;
      $display("FAIL endrop_second: data=%h sent=%0d tmo=%0d, want %h %0d",
               d, sent_cnt_o, tmo, ref_ascii(b), exp_sent);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] x, y;
    logic [7:0] d; logic sb, pb; int len, lat; bit tmo; int n; int p0;
    x = 4'($urandom_range(15));
    y = 4'($urandom_range(15));
    q.push_back(x);
    en_i = 1'b1;
    n = 0;
    while (txd_o !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (txd_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_start: txd=%b, want 0 (no frame started)", txd_o);
    end
    repeat (4 * CD + CD / 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_sent = 0;
    checks++;
    if (txd_o !== 1'b1 || deq_o !== 1'b0 || busy_o !== 1'b0 || sent_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_abort: txd=%b deq=%b busy=%b sent=%0d, want 1 0 0 0",
               txd_o, deq_o, busy_o, sent_cnt_o);
    end
    rst = 1'b1;
    p0 = pulse_cnt;
    q.push_back(y);
    capture_frame(-1, d, sb, pb, len, lat, tmo);
    exp_sent++;
    checks++;
    if (tmo || d !== ref_ascii(y) || len !== 10 * CD || lat !== RL || last_width !== DH) begin
      errors++;
      $display("FAIL rstmid_new: data=%h len=%0d lat=%0d w=%0d tmo=%0d, want %h %0d %0d %0d",
               d, len, lat, last_width, tmo, ref_ascii(y), 10 * CD, RL, DH);
    end
    checks++;
    if (sent_cnt_o !== 8'(exp_sent) || pulse_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL rstmid_count: sent=%0d pulses=%0d, want %0d 1", sent_cnt_o, pulse_cnt - p0, exp_sent);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mapping();
    test_random();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
